// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clk_div_sched divider controller.
package clk_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned DIV_W_DEF = 32;
   localparam int unsigned CNT_W_DEF = 16;

   // Zero means "one" for divisors and period counts; callers size-cast the result.
   function automatic logic [63:0] clamp_min1(input logic [63:0] v);
      return (v == 64'd0) ? 64'd1 : v;
   endfunction

endpackage

// File: rtl/clk_div_sched_if.sv
// Config handshake, run control and generated-clock outputs of clk_div_sched.
interface clk_div_sched_if
   import clk_div_pkg::*;
#(
   parameter int unsigned DIV_W = DIV_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [DIV_W-1:0] cfg_div;
   logic             cfg_oneshot;
   logic [CNT_W-1:0] cfg_count;
   logic             start;
   logic             stop;
   logic             tick;
   logic             div_clk;
   logic             busy;
   logic             done;
   logic [DIV_W-1:0] cur_div;

   modport master (
      output cfg_valid, cfg_div, cfg_oneshot, cfg_count, start, stop,
      input  cfg_ready, tick, div_clk, busy, done, cur_div
   );

   modport slave (
      input  cfg_valid, cfg_div, cfg_oneshot, cfg_count, start, stop,
      output cfg_ready, tick, div_clk, busy, done, cur_div
   );
endinterface

// File: rtl/div_counter.sv
// Up-counter that wraps to zero when it reaches limit-1; limit is never zero.
module div_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] limit_i,
   output logic         wrap_o
);
   logic [W-1:0] cnt_q, cnt_d;

   assign wrap_o = (cnt_q == limit_i - W'(1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = wrap_o ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/clk_div_sched.sv
// Divide-counter sequencer: boundary-aligned divisor reload, free-run and
// one-shot modes, a 1-cycle tick strobe and a 50% div_clk.
module clk_div_sched
   import clk_div_pkg::*;
#(
   parameter int unsigned DIV_W       = DIV_W_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned DEFAULT_DIV = 25_000_000
) (
   input  logic           clk,
   input  logic           n_rst,
   clk_div_sched_if.slave bus
);
   localparam logic [DIV_W-1:0] RST_DIV = (DEFAULT_DIV == 0) ? DIV_W'(1) : DIV_W'(DEFAULT_DIV);

   state_t           state_q, state_d;
   logic [DIV_W-1:0] active_div_q, active_div_d;
   logic [DIV_W-1:0] shadow_q, shadow_d;
   logic             pend_q, pend_d;
   logic             oneshot_q, oneshot_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic             div_clk_q, div_clk_d;

   logic             wrap, tick, cfg_ready, hs;
   logic [DIV_W-1:0] cfg_div_c;
   logic [CNT_W-1:0] cfg_cnt_c;

   div_counter #(.W(DIV_W)) u_cnt (
      .clk     (clk),
      .n_rst   (n_rst),
      .clr_i   ((state_q != RUN) || bus.stop),
      .en_i    (state_q == RUN),
      .limit_i (active_div_q),
      .wrap_o  (wrap)
   );

   assign tick      = (state_q == RUN) && wrap;
   assign cfg_ready = (state_q == IDLE) || ((state_q == RUN) && !pend_q);
   assign hs        = bus.cfg_valid && cfg_ready;
   assign cfg_div_c = DIV_W'(clamp_min1(64'(bus.cfg_div)));
   assign cfg_cnt_c = CNT_W'(clamp_min1(64'(bus.cfg_count)));

   always_comb begin
      state_d      = state_q;
      active_div_d = active_div_q;
      shadow_d     = shadow_q;
      pend_d       = pend_q;
      oneshot_d    = oneshot_q;
      remaining_d  = remaining_q;
      div_clk_d    = tick ? !div_clk_q : div_clk_q;
      case (state_q)
         IDLE: begin
            if (hs) begin
               active_div_d = cfg_div_c;
               oneshot_d    = bus.cfg_oneshot;
               remaining_d  = cfg_cnt_c;
            end
            if (bus.start && !bus.stop) state_d = RUN;
         end
         RUN: begin
            if (bus.stop) begin
               state_d = IDLE;
               pend_d  = 1'b0;
            end else if (tick) begin
               // A handshake landing on the boundary skips the shadow register.
               if (hs)          active_div_d = cfg_div_c;
               else if (pend_q) active_div_d = shadow_q;
               pend_d = 1'b0;
               if (oneshot_q) begin
                  if (remaining_q == CNT_W'(1)) state_d = DONE;
                  else                          remaining_d = remaining_q - CNT_W'(1);
               end
            end else if (hs) begin
               shadow_d = cfg_div_c;
               pend_d   = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         active_div_q <= RST_DIV;
         pend_q       <= 1'b0;
         oneshot_q    <= 1'b0;
         remaining_q  <= CNT_W'(1);
         div_clk_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         active_div_q <= active_div_d;
         pend_q       <= pend_d;
         oneshot_q    <= oneshot_d;
         remaining_q  <= remaining_d;
         div_clk_q    <= div_clk_d;
      end
   end

   always_ff @(posedge clk) begin
      shadow_q <= shadow_d;
   end

   assign bus.cfg_ready = cfg_ready;
   assign bus.tick      = tick;
   assign bus.div_clk   = div_clk_q;
   assign bus.busy      = (state_q == RUN);
   assign bus.done      = (state_q == DONE);
   assign bus.cur_div   = active_div_q;
endmodule
